ex_stage: RTL and testbench

//   Execute stage plus EX/MEM pipeline register. Consumes ID/EX outputs.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/ex_alu.sv | 24 ++
 rtl/ex_stage.sv | 164 ++++++++++++++++
 tb/tb_ex_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings and types for the execute stage: ALUOp/funct codes, ALU-control, FSM state.
// Also holds the default MUL occupancy and the packed EX/MEM register layout.
package cpu_pkg;

  localparam int MUL_CYCLES_DEF = 4;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [9:0] F_ADD = 10'b0000000_000;
  localparam logic [9:0] F_SUB = 10'b0100000_000;
  localparam logic [9:0] F_AND = 10'b0000000_111;
  localparam logic [9:0] F_XOR = 10'b0000000_100;
  localparam logic [9:0] F_SLL = 10'b0000000_001;
  localparam logic [9:0] F_MUL = 10'b0000001_000;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SRAI = 3'b101;

  typedef enum logic [2:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
  } alu_ctrl_e;

  typedef enum logic {ST_IDLE, ST_MUL_BUSY} ex_state_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
  } exmem_t;

endpackage

// File: rtl/ex_alu.sv
// Single-cycle combinational ALU; MUL and unknown controls yield 0 (MUL lives in ex_stage).
module ex_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_ctrl_e   ctrl_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLL: result_o = a_i << b_i[4:0];
      ALU_SRA: result_o = $signed(a_i) >>> b_i[4:0];
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage + EX/MEM register: 1-cycle ops, MUL occupies MUL_CYCLES cycles.
// stall_o holds upstream while a MUL is in flight; bubbles fill EX/MEM meanwhile.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        Branch_i,
  input  logic        MemRead_i,
  input  logic        MemtoReg_i,
  input  logic [1:0]  ALUOp_i,
  input  logic        MemWrite_i,
  input  logic        ALUSrc_i,
  input  logic        RegWrite_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [31:0] imm_i,
  input  logic [9:0]  funct_i,
  input  logic [4:0]  RDaddr_i,
  output logic        stall_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  alu_ctrl_e   alu_ctrl;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] product;
  logic        stall;

  ex_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  exmem_t           exmem_q, exmem_d;

  always_comb begin
    alu_ctrl = ALU_NONE;
    op_b     = RS2data_i;
    case (ALUOp_i)
      ALUOP_MEM: begin
        alu_ctrl = ALU_ADD;
        op_b     = imm_i;
      end
      ALUOP_BEQ: alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        op_b = ALUSrc_i ? imm_i : RS2data_i;
        case (funct_i)
          F_ADD:   alu_ctrl = ALU_ADD;
          F_SUB:   alu_ctrl = ALU_SUB;
          F_AND:   alu_ctrl = ALU_AND;
          F_XOR:   alu_ctrl = ALU_XOR;
          F_SLL:   alu_ctrl = ALU_SLL;
          F_MUL:   alu_ctrl = ALU_MUL;
          default: alu_ctrl = ALU_NONE;
        endcase
      end
      default: begin
        // funct7 carries immediate bits for I-type, so only funct3 selects the op
        op_b = imm_i;
        case (funct_i[2:0])
          F3_ADDI: alu_ctrl = ALU_ADD;
          F3_SRAI: alu_ctrl = ALU_SRA;
          default: alu_ctrl = ALU_NONE;
        endcase
      end
    endcase
  end

  ex_alu u_alu (
    .a_i      (RS1data_i),
    .b_i      (op_b),
    .ctrl_i   (alu_ctrl),
    .result_o (alu_res)
  );

  assign product = mul_a_q * mul_b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    stall   = 1'b0;

    exmem_d.alu_result = alu_res;
    exmem_d.mem_data   = RS2data_i;
    exmem_d.rd         = RDaddr_i;
    exmem_d.reg_write  = valid_i & RegWrite_i & (RDaddr_i != 5'd0);
    exmem_d.mem_to_reg = valid_i & MemtoReg_i;
    exmem_d.mem_read   = valid_i & MemRead_i;
    exmem_d.mem_write  = valid_i & MemWrite_i;

    case (state_q)
      ST_IDLE: begin
        if (valid_i && alu_ctrl == ALU_MUL) begin
          stall   = 1'b1;
          mul_a_d = RS1data_i;
          mul_b_d = op_b;
          cnt_d   = CNT_W'(1);
          state_d = ST_MUL_BUSY;
        end
      end
      default: begin
        if (cnt_q == CNT_LAST) begin
          exmem_d.alu_result = product;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    if (stall) begin
      exmem_d.reg_write  = 1'b0;
      exmem_d.mem_to_reg = 1'b0;
      exmem_d.mem_read   = 1'b0;
      exmem_d.mem_write  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      exmem_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      exmem_q <= exmem_d;
    end
  end

  assign stall_o         = stall;
  assign branch_taken_o  = valid_i & Branch_i & (RS1data_i == RS2data_i) & ~stall;
  assign branch_target_o = pc_i + (imm_i << 1);
  assign ALUResult_o     = exmem_q.alu_result;
  assign MemData_o       = exmem_q.mem_data;
  assign RDaddr_o        = exmem_q.rd;
  assign RegWrite_o      = exmem_q.reg_write;
  assign MemtoReg_o      = exmem_q.mem_to_reg;
  assign MemRead_o       = exmem_q.mem_read;
  assign MemWrite_o      = exmem_q.mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a transaction-level reference model.
module tb_ex_stage;
  localparam int MC = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i;
  logic [31:0] pc_i, RS1data_i, RS2data_i, imm_i;
  logic [1:0]  ALUOp_i;
  logic [9:0]  funct_i;
  logic [4:0]  RDaddr_i;
  logic        stall_o, branch_taken_o;
  logic [31:0] branch_target_o, ALUResult_o, MemData_o;
  logic [4:0]  RDaddr_o;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  ex_stage #(.MUL_CYCLES(MC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i), .Branch_i(Branch_i),
    .MemRead_i(MemRead_i), .MemtoReg_i(MemtoReg_i), .ALUOp_i(ALUOp_i), .MemWrite_i(MemWrite_i),
    .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
    .imm_i(imm_i), .funct_i(funct_i), .RDaddr_i(RDaddr_i), .stall_o(stall_o),
    .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
    .ALUResult_o(ALUResult_o), .MemData_o(MemData_o), .RDaddr_o(RDaddr_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o)
  );

  typedef struct {
    logic        valid, branch, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [1:0]  aluop;
    logic [31:0] pc, rs1, rs2, imm;
    logic [9:0]  funct;
    logic [4:0]  rd;
  } instr_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic instr_t blank();
    instr_t t;
    t = '{default: '0};
    return t;
  endfunction

  function automatic instr_t rtype(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd);
    instr_t t = blank();
    t.valid = 1; t.aluop = 2'b10; t.regwrite = 1; t.funct = f; t.rs1 = a; t.rs2 = b; t.rd = rd;
    return t;
  endfunction

  function automatic instr_t itype(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] imm,
                                   input logic [4:0] rd);
    instr_t t = blank();
    t.valid = 1; t.aluop = 2'b11; t.alusrc = 1; t.regwrite = 1;
    t.funct = {7'b0100000, f3}; t.rs1 = a; t.imm = imm; t.rd = rd;
    return t;
  endfunction

  function automatic instr_t memop(input logic store, input logic [31:0] a, input logic [31:0] imm,
                                   input logic [31:0] data, input logic [4:0] rd);
    instr_t t = blank();
    t.valid = 1; t.aluop = 2'b00; t.alusrc = 1; t.rs1 = a; t.imm = imm; t.rs2 = data; t.rd = rd;
    t.memwrite = store; t.memread = ~store; t.memtoreg = ~store; t.regwrite = ~store;
    return t;
  endfunction

  function automatic instr_t beq(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm);
    instr_t t = blank();
    t.valid = 1; t.aluop = 2'b01; t.branch = 1; t.pc = pc; t.rs1 = a; t.rs2 = b; t.imm = imm;
    return t;
  endfunction

  // Reference result straight from the op table
  function automatic logic [31:0] ref_result(input instr_t t);
    logic [31:0] b;
    b = t.alusrc ? t.imm : t.rs2;
    case (t.aluop)
      2'b00: return t.rs1 + t.imm;
      2'b01: return t.rs1 - t.rs2;
      2'b10: begin
        case (t.funct)
          10'b0000000_111: return t.rs1 & b;
          10'b0000000_100: return t.rs1 ^ b;
          10'b0000000_001: return t.rs1 << b[4:0];
          10'b0000000_000: return t.rs1 + b;
          10'b0100000_000: return t.rs1 - b;
          10'b0000001_000: return t.rs1 * b;
          default:         return 32'd0;
        endcase
      end
      default: begin
        case (t.funct[2:0])
          3'b000:  return t.rs1 + t.imm;
          3'b101:  return 32'($signed(t.rs1) >>> t.imm[4:0]);
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  function automatic bit is_mul(input instr_t t);
    return t.valid && t.aluop == 2'b10 && t.funct == 10'b0000001_000;
  endfunction

  task automatic drive(input instr_t t);
    valid_i = t.valid; pc_i = t.pc; Branch_i = t.branch; MemRead_i = t.memread;
    MemtoReg_i = t.memtoreg; ALUOp_i = t.aluop; MemWrite_i = t.memwrite; ALUSrc_i = t.alusrc;
    RegWrite_i = t.regwrite; RS1data_i = t.rs1; RS2data_i = t.rs2; imm_i = t.imm;
    funct_i = t.funct; RDaddr_i = t.rd;
  endtask

  // Present one instruction, hold it through any stall, and check the EX/MEM result
  task automatic run(input instr_t t);
    int nstall;
    nstall = is_mul(t) ? MC - 1 : 0;
    @(negedge clk_i);
    drive(t);
    for (int k = 0; k < nstall; k++) begin
      #1;
      check("mul_stall", stall_o, 1);
      check("mul_no_branch", branch_taken_o, 0);
      @(posedge clk_i); #1;
      check("mul_bubble_ctrl", {RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o}, 0);
      @(negedge clk_i);
    end
    #1;
    check("stall_low", stall_o, 0);
    check("branch_taken", branch_taken_o, t.valid & t.branch & (t.rs1 == t.rs2));
    check("branch_target", branch_target_o, t.pc + t.imm * 2);
    @(posedge clk_i); #1;
    check("regwrite", RegWrite_o, t.valid & t.regwrite & (t.rd != 0));
    check("memread", MemRead_o, t.valid & t.memread);
    check("memwrite", MemWrite_o, t.valid & t.memwrite);
    check("memtoreg", MemtoReg_o, t.valid & t.memtoreg);
    if (t.valid) begin
      check("alu_result", ALUResult_o, ref_result(t));
      check("mem_data", MemData_o, t.rs2);
      check("rd", RDaddr_o, t.rd);
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    logic [31:0] a, b, imm;
    logic [4:0] rd;
    int kind;
    a = $urandom; b = $urandom; imm = $urandom; rd = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 7) == 0) b = a;
    kind = $urandom_range(0, 12);
    case (kind)
      0: t = rtype(10'b0000000_000, a, b, rd);
      1: t = rtype(10'b0100000_000, a, b, rd);
      2: t = rtype(10'b0000000_111, a, b, rd);
      3: t = rtype(10'b0000000_100, a, b, rd);
      4: t = rtype(10'b0000000_001, a, b, rd);
      5: t = rtype(10'b0000001_000, a, b, rd);
      6: t = itype(3'b000, a, imm, rd);
      7: t = itype(3'b101, a, imm, rd);
      8: t = memop(1'b0, a, imm, b, rd);
      9: t = memop(1'b1, a, imm, b, rd);
      10: t = beq(a, a ^ 32'h5, ($urandom_range(0, 1) != 0) ? a ^ 32'h5 : b, imm);
      11: t = rtype(10'b1111111_010, a, b, rd);
      default: begin
        t = rtype(($urandom_range(0, 1) != 0) ? 10'b0000001_000 : 10'b0000000_000, a, b, rd);
        t.branch = 1; t.memwrite = 1; t.rs2 = a;
        t.valid = 0;
      end
    endcase
    t.pc = $urandom;
    if (kind == 6 || kind == 7) t.funct[9:3] = 7'($urandom);
    return t;
  endfunction

  initial begin
    instr_t t;
    drive(blank());
    rst_i = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_taken", branch_taken_o, 0);
    check("rst_result", ALUResult_o, 0);
    check("rst_ctrl", {RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o}, 0);
    check("rst_rd", RDaddr_o, 0);

    run(rtype(10'b0000000_000, 32'd5, 32'd7, 5'd3));
    check("add_literal", ALUResult_o, 32'd12);
    check("add_rd_literal", RDaddr_o, 5'd3);
    run(itype(3'b101, 32'hF000_0000, 32'd4, 5'd4));
    check("srai_literal", ALUResult_o, 32'hFF00_0000);
    run(rtype(10'b0000000_001, 32'h1, 32'd33, 5'd5));
    check("sll_shamt_wrap", ALUResult_o, 32'h2);
    run(memop(1'b1, 32'h100, 32'd8, 32'hDEAD, 5'd0));
    check("sw_addr", ALUResult_o, 32'h108);
    check("sw_data", MemData_o, 32'hDEAD);
    run(beq(32'h40, 32'd9, 32'd9, 32'd4));
    run(beq(32'h40, 32'd9, 32'd8, 32'd4));
    run(rtype(10'b0000000_000, 32'd1, 32'd1, 5'd0));
    run(rtype(10'b0000001_000, 32'h1_0000, 32'h1_0001, 5'd6));
    check("mul_literal", ALUResult_o, 32'h0001_0000);
    check("mul_regwrite", RegWrite_o, 1);
    run(rtype(10'b0000001_000, 32'hFFFF_FFFF, 32'd3, 5'd7));
    run(rtype(10'b0000001_000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8));

    for (int i = 0; i < 400; i++) begin
      t = rand_instr();
      run(t);
    end

    // Reset in the second cycle of a MUL discards it
    t = rtype(10'b0000001_000, 32'd6, 32'd7, 5'd9);
    @(negedge clk_i);
    drive(t);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("rst_mul_busy", stall_o, 1);
    rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0;
    valid_i = 0;
    #1;
    check("rst_mul_stall", stall_o, 0);
    check("rst_mul_result", ALUResult_o, 0);
    check("rst_mul_data", MemData_o, 0);
    check("rst_mul_ctrl", {RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o}, 0);
    for (int k = 0; k < MC + 2; k++) begin
      @(posedge clk_i); #1;
      check("rst_mul_no_product", {31'd0, ALUResult_o == 32'd42}, 0);
      check("rst_mul_no_write", RegWrite_o, 0);
      check("rst_mul_idle", stall_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
